// File: rtl/sample_counter_if.sv
// Bus bundle for sample_counter: control inputs and count/status outputs.
// Macro: none.
//   master : drives enable, load, load_val, dir; observes count, tc, wrap
//   slave  : the counter side of the same signals
interface sample_counter_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output enable, load, load_val, dir,
    input  count, tc, wrap
  );

  modport slave (
    input  enable, load, load_val, dir,
    output count, tc, wrap
  );
endinterface

// File: rtl/sample_counter.sv
// Up/down counter with programmable terminal value. It provides the sample ROM
// sequencer address index.
// Ports:
//   clk    : rising-edge clock
//   Reset  : synchronous, active-high; clears count and wrap
//   bus    : sample_counter_if.slave
//            enable/load/load_val/dir in; count (registered), tc (combinational),
//            wrap (registered one-cycle pulse) out
// Update priority per edge: Reset > load > enable > hold.
// Optional macro SAMPLE_COUNTER_SAT_EN: saturate at MAX/0 instead of wrapping;
// wrap is then never asserted.
module sample_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 2**WIDTH - 1
) (
  input logic               clk,
  input logic               Reset,
  sample_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
    end else if (bus.enable) begin
      if (bus.dir) begin
        // ">=" also recovers an out-of-range count as if it were at terminal.
        if (count_q >= MaxVal) begin
`ifdef SAMPLE_COUNTER_SAT_EN
          count_d = MaxVal;
`else
          count_d = '0;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (count_q == '0) begin
`ifdef SAMPLE_COUNTER_SAT_EN
          count_d = '0;
`else
          count_d = MaxVal;
          wrap_d  = 1'b1;
`endif
        end else begin
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.dir ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_sample_counter.sv
// Directed, table-driven bench for sample_counter with WIDTH=4, MAX=12.
// Each vector is applied at the falling edge and checked 1 time unit after the
// following rising edge (inputs still held, so tc reflects the vector's dir).
module tb_sample_counter;

  localparam int unsigned W = 4;
  localparam int unsigned M = 12;

  typedef struct {
    logic         rst;
    logic         ld;
    logic         en;
    logic         dir;
    logic [W-1:0] lv;
    logic [W-1:0] cnt;
    logic         tc;
    logic         wr;
  } vec_t;

  logic clk;
  logic Reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  sample_counter_if #(.WIDTH(W)) bus ();

  sample_counter #(
    .WIDTH (W),
    .MAX   (M)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic ld, input logic en, input logic dir,
                              input logic [W-1:0] lv, input logic [W-1:0] cnt,
                              input logic tc, input logic wr);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = en; v.dir = dir; v.lv = lv;
    v.cnt = cnt; v.tc = tc; v.wr = wr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic en, input logic dir,
                       input logic [W-1:0] lv);
    @(negedge clk);
    Reset        = rst;
    bus.load     = ld;
    bus.enable   = en;
    bus.dir      = dir;
    bus.load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    Reset        = 1'b1;
    bus.load     = 1'b0;
    bus.enable   = 1'b0;
    bus.dir      = 1'b1;
    bus.load_val = '0;

    //   rst ld en dir lv     cnt tc wr
    add(1, 0, 0, 1, 4'd0, 4'd0, 0, 0);
    add(1, 0, 0, 1, 4'd0, 4'd0, 0, 0);
`ifdef SAMPLE_COUNTER_SAT_EN
    add(0, 1, 0, 1, 4'd10, 4'd10, 0, 0);
    add(0, 0, 1, 1, 4'd0,  4'd11, 0, 0);
    add(0, 0, 1, 1, 4'd0,  4'd12, 1, 0);
    add(0, 0, 1, 1, 4'd0,  4'd12, 1, 0);
    add(0, 0, 1, 1, 4'd0,  4'd12, 1, 0);
    add(0, 0, 1, 1, 4'd0,  4'd12, 1, 0);
    add(0, 1, 0, 0, 4'd1,  4'd1,  0, 0);
    add(0, 0, 1, 0, 4'd0,  4'd0,  1, 0);
    add(0, 0, 1, 0, 4'd0,  4'd0,  1, 0);
    add(0, 1, 1, 1, 4'd15, 4'd12, 1, 0);
    add(1, 1, 1, 1, 4'd9,  4'd0,  0, 0);
`else
    // Up ramp 1..12, wrap to 0, then 1.
    for (int i = 1; i <= 12; i++) add(0, 0, 1, 1, 4'd0, W'(i), (i == 12), 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 0, 1);
    add(0, 0, 1, 1, 4'd0, 4'd1, 0, 0);
    for (int i = 2; i <= 7; i++) add(0, 0, 1, 1, 4'd0, W'(i), 0, 0);
    // Reset mid-count wins over enable, counting resumes at 1.
    add(1, 0, 1, 1, 4'd0, 4'd0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd1, 0, 0);
    // Load (enable ignored), clamp, then wrap from the clamped value.
    add(0, 1, 1, 1, 4'd5,  4'd5,  0, 0);
    add(0, 1, 1, 1, 4'd15, 4'd12, 1, 0);
    add(0, 0, 1, 1, 4'd0,  4'd0,  0, 1);
    // Down through zero.
    add(0, 1, 0, 0, 4'd1, 4'd1,  0, 0);
    add(0, 0, 1, 0, 4'd0, 4'd0,  1, 0);
    add(0, 0, 1, 0, 4'd0, 4'd12, 0, 1);
    add(0, 0, 1, 0, 4'd0, 4'd11, 0, 0);
    // Hold at 3.
    add(0, 1, 0, 1, 4'd3, 4'd3, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 4'd0, 4'd3, 0, 0);
    // Wrap pulse clears on a hold cycle.
    add(0, 1, 0, 1, 4'd12, 4'd12, 1, 0);
    add(0, 0, 1, 1, 4'd0,  4'd0,  0, 1);
    add(0, 0, 0, 1, 4'd0,  4'd0,  0, 0);
    // Reset suppresses a pending down-wrap, and overrides load.
    add(1, 0, 1, 0, 4'd0, 4'd0, 1, 0);
    add(1, 1, 1, 1, 4'd9, 4'd0, 0, 0);
    add(0, 0, 1, 1, 4'd0, 4'd1, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].dir, vecs[i].lv);
      check("count", i, bus.count, vecs[i].cnt);
      check("tc",    i, W'(bus.tc), W'(vecs[i].tc));
      check("wrap",  i, W'(bus.wrap), W'(vecs[i].wr));
    end

    // tc follows dir combinationally, with no clock edge in between.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    check("tc_up_at0", 100, W'(bus.tc), W'(1'b0));
    bus.dir = 1'b0;
    #1;
    check("tc_dn_at0", 101, W'(bus.tc), W'(1'b1));
    check("cnt_dirchg", 102, bus.count, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    check("tc_up_atmax", 103, W'(bus.tc), W'(1'b1));
    bus.dir = 1'b0;
    #1;
    check("tc_dn_atmax", 104, W'(bus.tc), W'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_counter.md
Name: sample_counter

Overview:
- Parameterised synchronous up/down counter with a programmable terminal value. It produces the address index for the sample ROM sequencer.
- The consumer watches `count` and `tc`, and restarts the sequence by pulsing `Reset`.
- The counter advances one step per enabled clock. It wraps at the terminal value and also supports parallel load.

Parameters:
- WIDTH, 4, bit width of `count` and `load_val`; must be >= 1.
- MAX, 2**WIDTH-1, terminal (highest) count value; legal range 0..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- Reset  input  1  reset, synchronous, active-high; clears all state.
- enable  input  1  count-advance qualifier; 1 = step this cycle.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when `load`=1.
- dir  input  1  count direction; 1 = up, 0 = down.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count flag, combinational from `count` and `dir`.
- wrap  output  1  registered one-cycle pulse marking a wrap event.

Behaviour:
- Update priority on each posedge `clk`: `Reset` > `load` > `enable` > hold.
- Reset:
  - `count` <= 0 and `wrap` <= 0.
  - `Reset` overrides `load` and `enable` in the same cycle.
  - Reset mid-sequence takes effect on the next edge with no partial step.
- Load:
  - `count` <= `load_val` and `wrap` <= 0.
  - If `load_val` > MAX, `count` <= MAX (clamp).
  - `enable` is ignored in a load cycle.
- Enable, up (`dir`=1):
  - `count` < MAX: `count` <= `count`+1, `wrap` <= 0.
  - `count` == MAX: `count` <= 0, `wrap` <= 1.
- Enable, down (`dir`=0):
  - `count` > 0: `count` <= `count`-1, `wrap` <= 0.
  - `count` == 0: `count` <= MAX, `wrap` <= 1.
- Hold (`enable`=0, no load, no reset): `count` unchanged, `wrap` <= 0.
- `wrap` is high for exactly one cycle, the cycle after the wrapping edge.
- `tc` = (`dir`=1 and `count`==MAX) or (`dir`=0 and `count`==0).
  - Zero latency; follows `dir` changes combinationally.
- Sequence length with `enable` held high is MAX+1 cycles per period, so latency from `enable` rising to the first increment is 1 edge.
- MAX=0: `count` stays 0, `tc`=1, and `wrap` pulses on every enabled cycle.
- A `dir` change takes effect on the next enabled edge; there is no extra state.
- Out-of-range `count` (> MAX) is unreachable. If it occurs (e.g. X-recovery), it is treated as at-terminal when up and wraps to 0.
- No X on outputs after the first `Reset` edge.

Optional Feature:
- Macro: SAMPLE_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Up: `count` stops at MAX with `enable` high.
  - Down: `count` stops at 0 with `enable` high.
  - `wrap` is never asserted (tied 0).
  - `tc` behaves unchanged.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
- WIDTH=4, MAX=12: assert `Reset` 2 cycles, then `dir`=1, `enable`=1 for 14 cycles -> `count` steps 0..12 then 0 and 1. `tc`=1 only at 12. `wrap`=1 only in the cycle `count`=0 follows 12.
- Reset mid-count: `count`=7, `Reset`=1 with `enable`=1 -> `count`=0 after the edge, `wrap`=0. Counting resumes at 1 after `Reset` drops.
- Load: `load`=1, `load_val`=5, `enable`=1 -> `count`=5. Then `load_val`=15 with MAX=12 -> `count`=12. Next enabled up edge -> 0 with a `wrap` pulse.
- Down: `dir`=0 from `count`=1 -> 0 (`tc`=1), then 12 with `wrap`=1, then 11.
- Hold: `enable`=0 for 5 cycles at `count`=3 -> `count` stays 3, `wrap`=0.
- SAMPLE_COUNTER_SAT_EN build: up from 10 with MAX=12 for 5 enabled cycles -> 11, 12, 12, 12, 12, `wrap` never asserted.
